// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC result path: float word width, the
// {cos,sin} result pair carried through the serializer FIFO, and the
// output FSM state encoding.
// ---------------------------------------------------------------------------
package cordic_pkg;

   localparam int CORDIC_FLOAT_W = 32;

   // One CORDIC result: cos in the upper half, sin in the lower half.
   typedef struct packed {
      logic [CORDIC_FLOAT_W-1:0] cos;
      logic [CORDIC_FLOAT_W-1:0] sin;
   } cordic_pair_t;

   // Output word sequencer: nothing presented, cos presented, sin presented.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COS  = 2'd1,
      ST_SIN  = 2'd2
   } ser_state_t;

endpackage : cordic_pkg

// File: rtl/cordic_result_fifo.sv
// ---------------------------------------------------------------------------
// cordic_result_fifo
// Synchronous FIFO of {cos,sin} result pairs. Push is ignored when full and
// pop is ignored when empty; full/empty come from the registered count, so a
// pop in the same cycle never frees room for a push (no bypass). The head
// entry is visible combinationally on rd_data. Drop/overflow policy belongs
// to the instantiating block.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (empties the FIFO)
//   push     in   write wr_data
//   wr_data  in   pair to write
//   pop      in   remove head entry
//   rd_data  out  head entry
//   count    out  occupancy 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0
// ---------------------------------------------------------------------------
module cordic_result_fifo
   import cordic_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  cordic_pair_t               wr_data,
   input  logic                       pop,
   output cordic_pair_t               rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   cordic_pair_t  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_r == (AW+1)'(DEPTH));
   assign empty     = (count_r == {(AW+1){1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign rd_data   = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers (wrap naturally at power-of-two DEPTH) and occupancy count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

endmodule : cordic_result_fifo

// File: rtl/cordic_result_serializer.sv
// ---------------------------------------------------------------------------
// cordic_result_serializer
// Captures CORDIC {cos,sin} result pairs into a FIFO and streams them out as
// 32-bit words (cos, then sin) over a valid/ready handshake. The upstream
// pipeline cannot stall, so pairs arriving at a full FIFO are dropped and a
// sticky overflow flag is raised; an almost-full level lets the system stop
// issuing new angles early.
//
// Optional feature macro: CORDIC_SERIALIZER_CNT_EN adds oPair_count (pairs
// fully delivered, wrapping) and oDrop_count (dropped pairs, saturating,
// cleared with the overflow flag).
//
// Ports:
//   iClk             in   clock
//   iReset_n         in   synchronous active-low reset
//   iData_valid      in   result pair valid this cycle
//   iData_cos        in   cos result word
//   iData_sin        in   sin result word
//   iClear_overflow  in   pulse clearing oOverflow
//   iReady           in   sink accepts oData
//   oValid           out  oData holds a word
//   oData            out  output word
//   oSin_flag        out  0 = cos word, 1 = sin word
//   oAlmost_full     out  FIFO occupancy >= ALMOST_FULL_LEVEL
//   oOverflow        out  sticky: a pair was dropped
//   oPair_count      out  (macro only) delivered pair count
//   oDrop_count      out  (macro only) dropped pair count
// ---------------------------------------------------------------------------
module cordic_result_serializer
   import cordic_pkg::*;
#(
   parameter int DEPTH             = 16,
   parameter int ALMOST_FULL_LEVEL = 12
) (
   input  logic                      iClk,
   input  logic                      iReset_n,
   input  logic                      iData_valid,
   input  logic [CORDIC_FLOAT_W-1:0] iData_cos,
   input  logic [CORDIC_FLOAT_W-1:0] iData_sin,
   input  logic                      iClear_overflow,
   input  logic                      iReady,
   output logic                      oValid,
   output logic [CORDIC_FLOAT_W-1:0] oData,
   output logic                      oSin_flag,
   output logic                      oAlmost_full,
`ifdef CORDIC_SERIALIZER_CNT_EN
   output logic [15:0]               oPair_count,
   output logic [7:0]                oDrop_count,
`endif
   output logic                      oOverflow
);

   localparam int AW = $clog2(DEPTH);

   ser_state_t                state_r;
   logic                      valid_r;
   logic [CORDIC_FLOAT_W-1:0] data_r;
   logic                      sin_flag_r;
   logic [CORDIC_FLOAT_W-1:0] hold_sin_r;
   logic                      almost_full_r;
   logic                      overflow_r;

   cordic_pair_t              wr_pair_s;
   cordic_pair_t              head_s;
   logic [AW:0]               fifo_count_s;
   logic [AW:0]               count_next_s;
   logic                      fifo_full_s;
   logic                      fifo_empty_s;
   logic                      push_s;
   logic                      pop_s;
   logic                      drop_s;

   assign wr_pair_s = '{cos: iData_cos, sin: iData_sin};
   assign push_s    = iData_valid & ~fifo_full_s;
   assign drop_s    = iData_valid & fifo_full_s;

   cordic_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (iClk),
      .rst_n   (iReset_n),
      .push    (push_s),
      .wr_data (wr_pair_s),
      .pop     (pop_s),
      .rd_data (head_s),
      .count   (fifo_count_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Pop decision: refill the holding register when idle, or right as the
   // sin word is accepted so back-to-back pairs stream without a bubble.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_IDLE: pop_s = ~fifo_empty_s;
         ST_SIN:  pop_s = iReady & ~fifo_empty_s;
         default: pop_s = 1'b0;
      endcase
   end

   // Occupancy after this edge, so the almost-full flag tracks the count.
   always_comb begin
      count_next_s = fifo_count_s;
      if (push_s && !pop_s) begin
         count_next_s = fifo_count_s + {{AW{1'b0}}, 1'b1};
      end else if (!push_s && pop_s) begin
         count_next_s = fifo_count_s - {{AW{1'b0}}, 1'b1};
      end else begin
         count_next_s = fifo_count_s;
      end
   end

   // Output word sequencer with registered valid/data/flag.
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_r    <= ST_IDLE;
         valid_r    <= 1'b0;
         data_r     <= {CORDIC_FLOAT_W{1'b0}};
         sin_flag_r <= 1'b0;
         hold_sin_r <= {CORDIC_FLOAT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  state_r    <= ST_COS;
                  valid_r    <= 1'b1;
                  data_r     <= head_s.cos;
                  sin_flag_r <= 1'b0;
                  hold_sin_r <= head_s.sin;
               end else begin
                  state_r    <= ST_IDLE;
                  valid_r    <= 1'b0;
               end
            end
            ST_COS: begin
               if (iReady) begin
                  state_r    <= ST_SIN;
                  data_r     <= hold_sin_r;
                  sin_flag_r <= 1'b1;
               end else begin
                  state_r    <= ST_COS;
               end
            end
            ST_SIN: begin
               if (iReady && !fifo_empty_s) begin
                  state_r    <= ST_COS;
                  data_r     <= head_s.cos;
                  sin_flag_r <= 1'b0;
                  hold_sin_r <= head_s.sin;
               end else if (iReady) begin
                  state_r    <= ST_IDLE;
                  valid_r    <= 1'b0;
                  data_r     <= {CORDIC_FLOAT_W{1'b0}};
                  sin_flag_r <= 1'b0;
               end else begin
                  state_r    <= ST_SIN;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               valid_r    <= 1'b0;
               data_r     <= {CORDIC_FLOAT_W{1'b0}};
               sin_flag_r <= 1'b0;
            end
         endcase
      end
   end

   // Almost-full level and sticky overflow; a drop beats a coincident clear.
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         almost_full_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         almost_full_r <= (count_next_s >= (AW+1)'(ALMOST_FULL_LEVEL));
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (iClear_overflow) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

`ifdef CORDIC_SERIALIZER_CNT_EN
   logic [15:0] pair_count_r;
   logic [7:0]  drop_count_r;

   // Delivered-pair counter (wraps) and dropped-pair counter (saturates).
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         pair_count_r <= 16'd0;
         drop_count_r <= 8'd0;
      end else begin
         if (state_r == ST_SIN && iReady) begin
            pair_count_r <= pair_count_r + 16'd1;
         end
         if (iClear_overflow) begin
            drop_count_r <= drop_s ? 8'd1 : 8'd0;
         end else if (drop_s && drop_count_r != 8'hFF) begin
            drop_count_r <= drop_count_r + 8'd1;
         end else begin
            drop_count_r <= drop_count_r;
         end
      end
   end

   assign oPair_count = pair_count_r;
   assign oDrop_count = drop_count_r;
`endif

   assign oValid       = valid_r;
   assign oData        = data_r;
   assign oSin_flag    = sin_flag_r;
   assign oAlmost_full = almost_full_r;
   assign oOverflow    = overflow_r;

endmodule : cordic_result_serializer

// File: tb/tb_cordic_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_cordic_result_serializer
// Self-checking bench. The reference model keeps the stored pairs in a queue
// and the words currently being offered in a second queue; every clock edge
// is replayed on the model and all outputs are compared afterwards.
// ---------------------------------------------------------------------------
module tb_cordic_result_serializer;

   localparam int DEPTH = 16;
   localparam int LEVEL = 12;

   logic        iClk = 1'b0;
   logic        iReset_n;
   logic        iData_valid;
   logic [31:0] iData_cos;
   logic [31:0] iData_sin;
   logic        iClear_overflow;
   logic        iReady;
   logic        oValid;
   logic [31:0] oData;
   logic        oSin_flag;
   logic        oAlmost_full;
   logic        oOverflow;
`ifdef CORDIC_SERIALIZER_CNT_EN
   logic [15:0] oPair_count;
   logic [7:0]  oDrop_count;
`endif

   always #5 iClk = ~iClk;

   cordic_result_serializer #(
      .DEPTH             (DEPTH),
      .ALMOST_FULL_LEVEL (LEVEL)
   ) dut (
      .iClk            (iClk),
      .iReset_n        (iReset_n),
      .iData_valid     (iData_valid),
      .iData_cos       (iData_cos),
      .iData_sin       (iData_sin),
      .iClear_overflow (iClear_overflow),
      .iReady          (iReady),
      .oValid          (oValid),
      .oData           (oData),
      .oSin_flag       (oSin_flag),
      .oAlmost_full    (oAlmost_full),
`ifdef CORDIC_SERIALIZER_CNT_EN
      .oPair_count     (oPair_count),
      .oDrop_count     (oDrop_count),
`endif
      .oOverflow       (oOverflow)
   );

   int checks   = 0;
   int failures = 0;

   // model state
   logic [63:0] m_q[$];      // stored pairs {cos,sin}
   logic [32:0] m_pres[$];   // words still to be offered {sin_flag, word}
   bit          m_ovf;
   logic [15:0] m_pairs;
   logic [7:0]  m_drops;
   int          sin_seen;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply the behaviour of one clock edge to the model using current inputs.
   task automatic model_edge();
      int pre_n;
      bit xfer, full_pre, dropped;
      logic [63:0] p;
      if (!iReset_n) begin
         m_q.delete();
         m_pres.delete();
         m_ovf   = 1'b0;
         m_pairs = 16'd0;
         m_drops = 8'd0;
         return;
      end
      pre_n    = m_pres.size();
      full_pre = (m_q.size() == DEPTH);
      xfer     = (pre_n > 0) && iReady;
      if (xfer) begin
         if (m_pres[0][32]) m_pairs = m_pairs + 16'd1;
         void'(m_pres.pop_front());
      end
      if ((pre_n == 0 || (pre_n == 1 && xfer)) && m_q.size() > 0) begin
         p = m_q.pop_front();
         m_pres.push_back({1'b0, p[63:32]});
         m_pres.push_back({1'b1, p[31:0]});
      end
      dropped = iData_valid && full_pre;
      if (iData_valid && !full_pre) m_q.push_back({iData_cos, iData_sin});
      if (dropped) m_ovf = 1'b1;
      else if (iClear_overflow) m_ovf = 1'b0;
      if (iClear_overflow) m_drops = dropped ? 8'd1 : 8'd0;
      else if (dropped && m_drops != 8'hFF) m_drops = m_drops + 8'd1;
   endtask

   task automatic compare();
      bit exp_valid;
      exp_valid = (m_pres.size() > 0);
      check_eq("valid", 32'(oValid), 32'(exp_valid));
      if (exp_valid) begin
         check_eq("data", oData, m_pres[0][31:0]);
         check_eq("sin_flag", 32'(oSin_flag), 32'(m_pres[0][32]));
      end
      check_eq("almost_full", 32'(oAlmost_full), 32'(m_q.size() >= LEVEL));
      check_eq("overflow", 32'(oOverflow), 32'(m_ovf));
`ifdef CORDIC_SERIALIZER_CNT_EN
      check_eq("pair_count", 32'(oPair_count), 32'(m_pairs));
      check_eq("drop_count", 32'(oDrop_count), 32'(m_drops));
`endif
   endtask

   // One clock: note a sin transfer, let the edge happen, update model, compare.
   task automatic tick();
      if (oValid && iReady && oSin_flag) sin_seen++;
      @(posedge iClk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic drive(input bit v, input logic [31:0] c, input logic [31:0] s,
                        input bit rdy, input bit clr);
      iData_valid     = v;
      iData_cos       = c;
      iData_sin       = s;
      iReady          = rdy;
      iClear_overflow = clr;
   endtask

   initial begin
      logic [31:0] a_cos, a_sin;
      iReset_n = 1'b0;
      sin_seen = 0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      m_pairs = 16'd0;
      m_drops = 8'd0;
      m_ovf   = 1'b0;
      repeat (3) tick();
      check_eq("rst_valid", 32'(oValid), 32'd0);
      check_eq("rst_data", oData, 32'd0);
      check_eq("rst_flag", 32'(oSin_flag), 32'd0);
      check_eq("rst_almost", 32'(oAlmost_full), 32'd0);
      check_eq("rst_ovf", 32'(oOverflow), 32'd0);
      iReset_n = 1'b1;
      tick();

      // single pair, sink always ready
      drive(1'b1, 32'h3F800000, 32'h00000000, 1'b1, 1'b0);
      tick();
      check_eq("lat_E_valid", 32'(oValid), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check_eq("lat_E1_valid", 32'(oValid), 32'd1);
      check_eq("single_cos", oData, 32'h3F800000);
      check_eq("single_cos_flag", 32'(oSin_flag), 32'd0);
      tick();
      check_eq("single_sin", oData, 32'h00000000);
      check_eq("single_sin_flag", 32'(oSin_flag), 32'd1);
      tick();
      check_eq("single_end_valid", 32'(oValid), 32'd0);

      // stall while cos is offered
      a_cos = $urandom;
      a_sin = $urandom;
      drive(1'b1, a_cos, a_sin, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("stall_hold", oData, a_cos);
      end
      iReady = 1'b1;
      tick();
      check_eq("stall_release_sin", oData, a_sin);
      tick();

      // burst of 20 pairs with sink stalled
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      check_eq("burst_ovf", 32'(oOverflow), 32'd1);
      check_eq("burst_almost", 32'(oAlmost_full), 32'd1);
      // cos accepted, then sin accepted together with a write at full
      iReady = 1'b1;
      tick();
      drive(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      tick();
      // refill to full, then clear coinciding with another drop
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      tick();
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b1);
      tick();
      check_eq("clear_vs_drop", 32'(oOverflow), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      check_eq("clear_ovf", 32'(oOverflow), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      sin_seen = 0;
      for (int i = 0; i < 60; i++) tick();
      check_eq("drain_pairs", 32'(sin_seen), 32'd17);
      check_eq("drain_idle", 32'(oValid), 32'd0);

      // reset after the cos word of a pair was transferred
      drive(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      tick();
      check_eq("mid_pair_is_sin", 32'(oSin_flag), 32'd1);
      iReset_n = 1'b0;
      tick();
      check_eq("mid_rst_valid", 32'(oValid), 32'd0);
      check_eq("mid_rst_almost", 32'(oAlmost_full), 32'd0);
      iReset_n = 1'b1;
      a_cos = $urandom;
      drive(1'b1, a_cos, $urandom, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check_eq("fresh_cos", oData, a_cos);
      check_eq("fresh_flag", 32'(oSin_flag), 32'd0);
      tick();
      tick();

`ifdef CORDIC_SERIALIZER_CNT_EN
      iReset_n = 1'b0;
      tick();
      iReset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b1, 1'b0);
         tick();
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         tick();
      end
      repeat (4) tick();
      check_eq("pair_count_3", 32'(oPair_count), 32'd3);
      for (int i = 0; i < 320; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
         tick();
      end
      check_eq("drop_sat", 32'(oDrop_count), 32'hFF);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      tick();
      iClear_overflow = 1'b0;
      repeat (40) tick();
`endif

      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) < 55, $urandom, $urandom,
               $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
         iReset_n = ($urandom_range(0, 999) >= 4);
         tick();
      end
      iReset_n = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (40) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cordic_result_serializer
